airi5c_round_arbiter: RTL



---
 rtl/airi5c_round_arbiter_pkg.sv | 27 ++
 rtl/airi5c_rounding_logic.sv | 26 ++
 rtl/airi5c_round_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/airi5c_round_arbiter_pkg.sv
// Shared FPU rounding-mode encodings and the round-increment decision rule.
package airi5c_round_arbiter_pkg;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  // Decide whether the truncated magnitude must be incremented by one ulp.
  // Unused encodings (5..7) never increment, i.e. they behave as RTZ.
  function automatic logic round_up(input logic [2:0] rm, input logic sgn,
                                    input logic lsb, input logic round_bit,
                                    input logic sticky);
    logic up;
    case (rm)
      RM_RNE:  up = round_bit && (sticky || lsb);
      RM_RTZ:  up = 1'b0;
      RM_RDN:  up = sgn && (round_bit || sticky);
      RM_RUP:  up = !sgn && (round_bit || sticky);
      RM_RMM:  up = round_bit;
      default: up = 1'b0;
    endcase
    return up;
  endfunction

endpackage

// File: rtl/airi5c_rounding_logic.sv
// Rounds an N-bit truncated magnitude using round/sticky bits and the
// rounding mode; the extra MSB of man_r is the carry out of the increment.
module airi5c_rounding_logic
  import airi5c_round_arbiter_pkg::*;
#(
  parameter int N = 23
) (
  input  logic [N-1:0] man,
  input  logic         round_bit,
  input  logic         sticky,
  input  logic         sgn,
  input  logic [2:0]   rm,
  output logic [N:0]   man_r,
  output logic         inexact
);

  logic inc;

  // Increment decision and carry-propagating add.
  always_comb begin
    inc     = round_up(rm, sgn, man[0], round_bit, sticky);
    man_r   = {1'b0, man} + (N+1)'(inc);
    inexact = round_bit || sticky;
  end

endmodule

// File: rtl/airi5c_round_arbiter.sv
// Shared FPU rounding stage: round-robin arbitration between execution
// units, one rounding per cycle, exponent/overflow repack and a registered
// IEEE-754 result with requester ID and NX/OF flags.
module airi5c_round_arbiter
  import airi5c_round_arbiter_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                     clk,
  input  logic                     n_reset,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ-1:0]         req_sgn,
  input  logic [N_REQ*EXP_W-1:0]   req_exp,
  input  logic [N_REQ*MAN_W-1:0]   req_man,
  input  logic [N_REQ-1:0]         req_round,
  input  logic [N_REQ-1:0]         req_sticky,
  input  logic [N_REQ*3-1:0]       req_rm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ID_W-1:0]          out_id,
  output logic [EXP_W+MAN_W:0]     out_result,
  output logic                     out_nx,
  output logic                     out_of
);

  localparam int RES_W = 1 + EXP_W + MAN_W;
  localparam logic [EXP_W-1:0] EXP_ONES    = '1;
  localparam logic [EXP_W-1:0] EXP_MAX_FIN = {{(EXP_W-1){1'b1}}, 1'b0};

  logic [EXP_W-1:0] exp_arr [N_REQ];
  logic [MAN_W-1:0] man_arr [N_REQ];
  logic [2:0]       rm_arr  [N_REQ];

  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  winner;
  logic             grant_any;
  logic             accept_en;
  logic             transfer;

  logic             sel_sgn;
  logic [EXP_W-1:0] sel_exp;
  logic [MAN_W-1:0] sel_man;
  logic [MAN_W:0]   man_r;
  logic             inexact;
  logic [RES_W+1:0] packed_res;

  logic             vld_p1;
  logic [ID_W-1:0]  id_p1;
  logic [RES_W-1:0] result_p1;
  logic             nx_p1;
  logic             of_p1;

  // Repack the rounded fraction: Inf/NaN passthrough, mantissa carry into
  // the exponent, and overflow to infinity. Returns {of, nx, result}.
  function automatic logic [RES_W+1:0] repack(input logic sgn,
                                              input logic [EXP_W-1:0] e,
                                              input logic [MAN_W-1:0] man,
                                              input logic [MAN_W:0] rnd,
                                              input logic nx);
    logic [RES_W+1:0] r;
    if (e == EXP_ONES)
      r = {2'b00, sgn, e, man};
    else if (!rnd[MAN_W])
      r = {1'b0, nx, sgn, e, rnd[MAN_W-1:0]};
    else if (e == EXP_MAX_FIN)
      r = {2'b11, sgn, EXP_ONES, {MAN_W{1'b0}}};
    else
      r = {1'b0, nx, sgn, e + EXP_W'(1), {MAN_W{1'b0}}};
    return r;
  endfunction

  // Split the packed requester buses into per-requester fields.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      exp_arr[i] = req_exp[i*EXP_W +: EXP_W];
      man_arr[i] = req_man[i*MAN_W +: MAN_W];
      rm_arr[i]  = req_rm[i*3 +: 3];
    end
  end

  // Round-robin search: first valid requester starting at ptr, wrapping.
  always_comb begin
    int              idx_i;
    logic [ID_W-1:0] idx;
    grant_any = 1'b0;
    winner    = '0;
    idx_i     = 0;
    idx       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx_i = int'(ptr) + k;
      if (idx_i >= N_REQ) idx_i = idx_i - N_REQ;
      idx = ID_W'(idx_i);
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        winner    = idx;
      end
    end
  end

  // Handshake: the output slot is free or draining this cycle; held in
  // reset so nobody sees ready while n_reset is low.
  always_comb begin
    accept_en = n_reset && (!vld_p1 || out_ready);
    transfer  = accept_en && grant_any;
    req_ready = '0;
    if (transfer) req_ready[winner] = 1'b1;
  end

  // Winner's operands into the shared rounder, then repack.
  always_comb begin
    sel_sgn    = req_sgn[winner];
    sel_exp    = exp_arr[winner];
    sel_man    = man_arr[winner];
    packed_res = repack(sel_sgn, sel_exp, sel_man, man_r, inexact);
  end

  airi5c_rounding_logic #(
    .N (MAN_W)
  ) u_rounding (
    .man       (sel_man),
    .round_bit (req_round[winner]),
    .sticky    (req_sticky[winner]),
    .sgn       (sel_sgn),
    .rm        (rm_arr[winner]),
    .man_r     (man_r),
    .inexact   (inexact)
  );

  // ---- stage p1: output register and round-robin pointer ----
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      vld_p1    <= 1'b0;
      id_p1     <= '0;
      result_p1 <= '0;
      nx_p1     <= 1'b0;
      of_p1     <= 1'b0;
      ptr       <= '0;
    end else if (accept_en) begin
      vld_p1 <= grant_any;
      if (grant_any) begin
        id_p1     <= winner;
        result_p1 <= packed_res[RES_W-1:0];
        nx_p1     <= packed_res[RES_W];
        of_p1     <= packed_res[RES_W+1];
        ptr       <= (winner == ID_W'(N_REQ-1)) ? '0 : winner + ID_W'(1);
      end
    end
  end

  assign out_valid  = vld_p1;
  assign out_id     = id_p1;
  assign out_result = result_p1;
  assign out_nx     = nx_p1;
  assign out_of     = of_p1;

endmodule
